// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared control-flow encodings for the PC sequencer
package cpu_ctrl_pkg;

    // Decoded jump type presented by decode
    localparam logic [1:0] JT_NONE = 2'b00;
    localparam logic [1:0] JT_J    = 2'b01;
    localparam logic [1:0] JT_JAL  = 2'b10;
    localparam logic [1:0] JT_JR   = 2'b11;

    // Sequencer states
    typedef enum logic [1:0] {
        SEQ_RUN   = 2'd0,
        SEQ_LINK  = 2'd1,
        SEQ_FLUSH = 2'd2
    } seq_state_t;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/jump_target_calc.sv
// rtl/jump_target_calc.sv - combinational redirect target selection
module jump_target_calc
    import cpu_ctrl_pkg::*;
(
    input  logic        instr_valid,
    input  logic [1:0]  jtype,
    input  logic [31:0] instr_pc,
    input  logic [25:0] target_addr,
    input  logic [31:0] rs_value,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic [31:0] target,
    output logic        redirect,
    output logic        is_link,
    output logic        misalign
);

    // Jumps take priority over a taken branch; nothing redirects without instr_valid
    always_comb begin
        target   = br_target;
        redirect = 1'b0;
        is_link  = 1'b0;
        misalign = 1'b0;
        if (instr_valid) begin
            case (jtype)
                JT_J: begin
                    target   = {instr_pc[31:28], target_addr, 2'b00};
                    redirect = 1'b1;
                end
                JT_JAL: begin
                    target   = {instr_pc[31:28], target_addr, 2'b00};
                    redirect = 1'b1;
                    is_link  = 1'b1;
                end
                JT_JR: begin
                    target   = {rs_value[31:2], 2'b00};
                    redirect = 1'b1;
                    misalign = |rs_value[1:0];
                end
                default: begin
                    target   = br_target;
                    redirect = br_taken;
                end
            endcase
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - architectural PC owner and redirect sequencer
module pc_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = DEFAULT_RESET_PC,
    parameter int          FLUSH_CYCLES = 1,
    parameter logic [4:0]  RA_REG       = 5'd31
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_in,
    input  logic        instr_valid,
    input  logic [1:0]  jtype,
    input  logic [31:0] instr_pc,
    input  logic [25:0] target_addr,
    input  logic [31:0] rs_value,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        rf_wr_req,
    input  logic        rf_wr_ack,
    output logic [4:0]  rf_wr_addr,
    output logic [31:0] rf_wr_data,
    output logic [31:0] pc,
    output logic        fetch_en,
    output logic        flush,
    output logic        busy,
    output logic        misalign_err
);

    // Counter counts down to zero, so it is loaded with one less than the bubble count
    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

    seq_state_t  state_q, state_d;
    logic [2:0]  flush_cnt_q;
    logic [31:0] pc_q, target_q, link_data_q;
    logic        misalign_q;

    logic [31:0] calc_target;
    logic        calc_redirect, calc_is_link, calc_misalign;
    logic        take_redirect;

    jump_target_calc u_target_calc (
        .instr_valid (instr_valid),
        .jtype       (jtype),
        .instr_pc    (instr_pc),
        .target_addr (target_addr),
        .rs_value    (rs_value),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .target      (calc_target),
        .redirect    (calc_redirect),
        .is_link     (calc_is_link),
        .misalign    (calc_misalign)
    );

    // Requests are only honoured in RUN with the pipeline moving
    assign take_redirect = (state_q == SEQ_RUN) && !stall_in && calc_redirect;

    // Next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            SEQ_RUN: begin
                if (take_redirect) begin
                    state_d = calc_is_link ? SEQ_LINK : SEQ_FLUSH;
                end
            end
            SEQ_LINK: begin
                if (rf_wr_ack) begin
                    state_d = SEQ_FLUSH;
                end
            end
            SEQ_FLUSH: begin
                if (flush_cnt_q == 3'd0) begin
                    state_d = SEQ_RUN;
                end
            end
            default: state_d = SEQ_RUN;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SEQ_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // PC, latched target, link data, bubble counter and misalign pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            target_q    <= 32'd0;
            link_data_q <= 32'd0;
            flush_cnt_q <= 3'd0;
            misalign_q  <= 1'b0;
        end else begin
            misalign_q <= take_redirect && calc_misalign;
            case (state_q)
                SEQ_RUN: begin
                    if (!stall_in) begin
                        if (calc_redirect) begin
                            pc_q        <= calc_target;
                            target_q    <= calc_target;
                            flush_cnt_q <= FLUSH_LOAD;
                            if (calc_is_link) begin
                                link_data_q <= instr_pc + 32'd4;
                            end
                        end else begin
                            pc_q <= pc_q + 32'd4;
                        end
                    end
                end
                SEQ_LINK: begin
                    if (rf_wr_ack) begin
                        pc_q        <= target_q;
                        flush_cnt_q <= FLUSH_LOAD;
                    end
                end
                SEQ_FLUSH: begin
                    if (flush_cnt_q != 3'd0) begin
                        flush_cnt_q <= flush_cnt_q - 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs are registers or pure state decodes
    assign pc           = pc_q;
    assign fetch_en     = (state_q == SEQ_RUN);
    assign flush        = (state_q != SEQ_RUN);
    assign busy         = (state_q != SEQ_RUN);
    assign rf_wr_req    = (state_q == SEQ_LINK);
    assign rf_wr_addr   = (state_q == SEQ_LINK) ? RA_REG : 5'd0;
    assign rf_wr_data   = link_data_q;
    assign misalign_err = misalign_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - scoreboard bench for pc_sequencer
module tb_pc_sequencer;

    localparam int          FC  = 1;
    localparam logic [31:0] RPC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_in = 1'b0;
    logic        instr_valid = 1'b0;
    logic [1:0]  jtype = 2'b00;
    logic [31:0] instr_pc = 32'd0;
    logic [25:0] target_addr = 26'd0;
    logic [31:0] rs_value = 32'd0;
    logic        br_taken = 1'b0;
    logic [31:0] br_target = 32'd0;
    logic        rf_wr_ack = 1'b0;
    logic        rf_wr_req;
    logic [4:0]  rf_wr_addr;
    logic [31:0] rf_wr_data;
    logic [31:0] pc;
    logic        fetch_en, flush, busy, misalign_err;

    pc_sequencer #(.RESET_PC(RPC), .FLUSH_CYCLES(FC), .RA_REG(5'd31)) dut (
        .clk(clk), .rst(rst), .stall_in(stall_in), .instr_valid(instr_valid),
        .jtype(jtype), .instr_pc(instr_pc), .target_addr(target_addr),
        .rs_value(rs_value), .br_taken(br_taken), .br_target(br_target),
        .rf_wr_req(rf_wr_req), .rf_wr_ack(rf_wr_ack), .rf_wr_addr(rf_wr_addr),
        .rf_wr_data(rf_wr_data), .pc(pc), .fetch_en(fetch_en), .flush(flush),
        .busy(busy), .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    bit mon_en = 1'b0;

    logic [31:0] fetch_q[$];
    logic [36:0] link_q[$];
    int          mis_q[$];
    bit          run_q[$];

    // Reference model: next fetch address, bubbles left, waiting for link ack
    logic [31:0] m_pc = RPC;
    int          m_bubble = 0;
    bit          m_link = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    task automatic fail_empty(input string name);
        total++;
        bad++;
        $display("FAIL %s cycle=%0d got=unexpected-event want=none", name, cyc);
    endtask

    // Predicts this cycle's visible behaviour, then advances by the spec's rules
    task automatic model_step();
        bit running;
        logic [31:0] tgt;
        running = !m_link && (m_bubble == 0);
        run_q.push_back(running);
        if (running && !stall_in) fetch_q.push_back(m_pc);
        if (rst) begin
            m_pc = RPC;
            m_bubble = 0;
            m_link = 1'b0;
            link_q.delete();
            return;
        end
        if (running) begin
            if (!stall_in) begin
                if (instr_valid && (jtype != 2'b00 || br_taken)) begin
                    if (jtype == 2'b01 || jtype == 2'b10)
                        tgt = (instr_pc & 32'hF000_0000) | (32'(target_addr) << 2);
                    else if (jtype == 2'b11)
                        tgt = rs_value & ~32'd3;
                    else
                        tgt = br_target;
                    m_pc = tgt;
                    if (jtype == 2'b10) begin
                        m_link = 1'b1;
                        link_q.push_back({5'd31, instr_pc + 32'd4});
                    end else begin
                        m_bubble = FC;
                    end
                    if (jtype == 2'b11 && rs_value[1:0] != 2'b00) mis_q.push_back(cyc + 1);
                end else begin
                    m_pc = m_pc + 32'd4;
                end
            end
        end else if (m_link) begin
            if (rf_wr_ack) begin
                m_link = 1'b0;
                m_bubble = FC;
            end
        end else begin
            m_bubble--;
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] jt, input logic [31:0] ipc,
                         input logic [25:0] ta, input logic [31:0] rs, input logic bt,
                         input logic [31:0] btgt, input logic st, input logic ack,
                         input logic r);
        instr_valid = v; jtype = jt; instr_pc = ipc; target_addr = ta; rs_value = rs;
        br_taken = bt; br_target = btgt; stall_in = st; rf_wr_ack = ack; rst = r;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic ack);
        for (int i = 0; i < n; i++) drive(1'b0, 2'b00, 32'd0, 26'd0, 32'd0, 1'b0, 32'd0, 1'b0, ack, 1'b0);
    endtask

    // Monitor: pops expectations whenever the DUT shows an observable event
    always @(negedge clk) begin
        if (mon_en) begin
            if (run_q.size() == 0) fail_empty("status_underflow");
            else begin
                bit r;
                r = run_q.pop_front();
                check("fetch_en", {31'd0, fetch_en}, {31'd0, r});
                check("flush", {31'd0, flush}, {31'd0, !r});
                check("busy", {31'd0, busy}, {31'd0, !r});
            end
            if (fetch_en && !stall_in) begin
                if (fetch_q.size() == 0) fail_empty("fetch_unexpected");
                else check("fetch_pc", pc, fetch_q.pop_front());
            end
            if (rf_wr_req) check("rf_wr_addr_req", {27'd0, rf_wr_addr}, 32'd31);
            else check("rf_wr_addr_idle", {27'd0, rf_wr_addr}, 32'd0);
            if (rf_wr_req && rf_wr_ack && !rst) begin
                if (link_q.size() == 0) fail_empty("link_unexpected");
                else begin
                    logic [36:0] e;
                    e = link_q.pop_front();
                    check("link_addr", {27'd0, rf_wr_addr}, {27'd0, e[36:32]});
                    check("link_data", rf_wr_data, e[31:0]);
                end
            end
            if (misalign_err) begin
                if (mis_q.size() == 0) fail_empty("misalign_unexpected");
                else check("misalign_cycle", cyc, mis_q.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog cycle=%0d got=timeout want=finish", cyc);
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_pc", pc, RPC);
        check("reset_fetch_en", {31'd0, fetch_en}, 32'd1);
        check("reset_flush", {31'd0, flush}, 32'd0);
        check("reset_req", {31'd0, rf_wr_req}, 32'd0);
        check("reset_data", rf_wr_data, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_misalign", {31'd0, misalign_err}, 32'd0);
        mon_en = 1'b1;

        idle(4, 1'b0);
        // plain j
        drive(1'b1, 2'b01, 32'hA000_0010, 26'h0000040, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        idle(3, 1'b0);
        // jal with ack held off for three cycles
        drive(1'b1, 2'b10, 32'h0000_0020, 26'h0000100, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        idle(3, 1'b0);
        idle(1, 1'b1);
        idle(3, 1'b0);
        // misaligned jr
        drive(1'b1, 2'b11, 32'h0000_0500, 26'd0, 32'h0000_1003, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        idle(3, 1'b0);
        // j together with taken branch
        drive(1'b1, 2'b01, 32'h3000_0000, 26'h0000222, 32'd0, 1'b1, 32'h0000_7770, 1'b0, 1'b0, 1'b0);
        idle(2, 1'b0);
        // branch alone, then branch without instr_valid
        drive(1'b1, 2'b00, 32'd0, 26'd0, 32'd0, 1'b1, 32'h0000_0800, 1'b0, 1'b0, 1'b0);
        idle(2, 1'b0);
        drive(1'b0, 2'b00, 32'd0, 26'd0, 32'd0, 1'b1, 32'h0000_0900, 1'b0, 1'b0, 1'b0);
        idle(2, 1'b0);
        // reset while waiting in LINK
        drive(1'b1, 2'b10, 32'h0000_0040, 26'h0000010, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        idle(1, 1'b0);
        drive(1'b0, 2'b00, 32'd0, 26'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        idle(3, 1'b0);
        // wrap past the top of the address space
        drive(1'b1, 2'b11, 32'd0, 26'd0, 32'hFFFF_FFFC, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        idle(4, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)), $urandom,
                  26'($urandom), $urandom, $urandom_range(0, 1) == 1, $urandom,
                  $urandom_range(0, 4) == 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 199) == 0);
        end
        idle(12, 1'b1);

        check("link_queue_left", link_q.size(), 32'd0);
        check("misalign_queue_left", mis_q.size(), 32'd0);
        check("fetch_queue_left", fetch_q.size(), 32'd0);
        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
